// File: rtl/ibus_responder_if.sv
// Instruction-bus request/response types and the fetch<->responder interface.
// The fetch stage drives the master modport; ibus_responder uses the slave modport.
package ibus_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

interface ibus_responder_if;
    import ibus_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;

    modport master (output ireq, input iresp);
    modport slave  (input ireq, output iresp);
endinterface

// File: rtl/ibus_responder.sv
// Instruction-bus responder: turns each accepted fetch into a read on the memory channel.
// Optional one-line fetch buffer is enabled with `define IBUS_LINEBUF_EN.
module ibus_responder
    import ibus_pkg::*;
#(
    parameter logic [31:0] PADDR_MASK = 32'h1FFF_FFFF,
    parameter int          LINE_WORDS = 4
) (
    input  logic             clk,
    input  logic             resetn,
    ibus_responder_if.slave  ibus,
    input  logic             linebuf_inv,
    output logic             mem_ar_valid,
    input  logic             mem_ar_ready,
    output logic [31:0]      mem_ar_addr,
    output logic [3:0]       mem_ar_len,
    input  logic             mem_r_valid,
    output logic             mem_r_ready,
    input  logic [31:0]      mem_r_data,
    input  logic             mem_r_last,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid and its payload stay stable until then. addr_ok/data_ok are one-cycle strobes.
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [31:0] ar_addr_q;
    logic [3:0]  ar_len_q;
    logic [31:0] resp_data_q;
    logic        accept;
    logic        hit;
    logic        data_done;
    logic [31:0] paddr;

    assign accept = (state_q == IDLE) && ibus.ireq.valid;
    assign paddr  = ibus.ireq.addr & PADDR_MASK & ~32'h3;

`ifdef IBUS_LINEBUF_EN
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int TAG_LSB = OFF_W + 2;

    logic [31:0]      buf_q [LINE_WORDS];
    logic [31:0]      buf_base_q;
    logic             buf_valid_q;
    logic             burst_q;
    logic             inv_seen_q;
    logic [OFF_W-1:0] word_idx_q;
    logic [OFF_W-1:0] beat_q;
    logic             cached;
    logic [OFF_W-1:0] req_idx;
    logic [31:0]      line_base;

    // kseg1 (virtual 0xA000_0000..0xBFFF_FFFF) is uncached and bypasses the buffer
    assign cached    = ibus.ireq.addr[31:29] != 3'b101;
    assign req_idx   = paddr[TAG_LSB-1:2];
    assign line_base = {paddr[31:TAG_LSB], {TAG_LSB{1'b0}}};
    assign hit       = cached && buf_valid_q && (buf_base_q == line_base);
    assign data_done = mem_r_valid && (!burst_q || mem_r_last);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            resp_data_q <= '0;
            buf_base_q  <= '0;
            buf_valid_q <= 1'b0;
            burst_q     <= 1'b0;
            inv_seen_q  <= 1'b0;
            word_idx_q  <= '0;
            beat_q      <= '0;
        end else begin
            if (accept) begin
                if (hit) begin
                    resp_data_q <= buf_q[req_idx];
                end else if (cached) begin
                    ar_addr_q   <= line_base;
                    ar_len_q    <= 4'(LINE_WORDS - 1);
                    burst_q     <= 1'b1;
                    word_idx_q  <= req_idx;
                    beat_q      <= '0;
                    inv_seen_q  <= 1'b0;
                    buf_valid_q <= 1'b0;
                end else begin
                    ar_addr_q <= paddr;
                    ar_len_q  <= '0;
                    burst_q   <= 1'b0;
                end
            end
            if (state_q == DATA && mem_r_valid) begin
                if (!burst_q) begin
                    resp_data_q <= mem_r_data;
                end else begin
                    if (beat_q == word_idx_q) resp_data_q <= mem_r_data;
                    beat_q <= beat_q + 1'b1;
                    if (mem_r_last) begin
                        buf_base_q  <= ar_addr_q;
                        buf_valid_q <= !inv_seen_q;
                    end
                end
            end
            // An invalidate seen mid-fill must leave the freshly filled line unusable
            if (state_q != IDLE && linebuf_inv) inv_seen_q <= 1'b1;
            if (linebuf_inv) buf_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == DATA && mem_r_valid && burst_q) buf_q[beat_q] <= mem_r_data;
    end
`else
    logic unused_ok;

    assign hit       = 1'b0;
    assign data_done = mem_r_valid;
    assign unused_ok = ^{linebuf_inv, mem_r_last, 32'(LINE_WORDS)};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            resp_data_q <= '0;
        end else begin
            if (accept) begin
                ar_addr_q <= paddr;
                ar_len_q  <= '0;
            end
            if (state_q == DATA && mem_r_valid) resp_data_q <= mem_r_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ibus.ireq.valid) state_d = hit ? RESP : ADDR;
            ADDR:    if (mem_ar_ready) state_d = DATA;
            DATA:    if (data_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // addr_ok is gated by resetn so every output reads 0 while reset is held
    always_comb begin
        ibus.iresp.addr_ok = resetn && (state_q == IDLE) && ibus.ireq.valid;
        ibus.iresp.data_ok = (state_q == RESP);
        ibus.iresp.data    = resp_data_q;
        mem_ar_valid       = (state_q == ADDR);
        mem_ar_addr        = ar_addr_q;
        mem_ar_len         = ar_len_q;
        mem_r_ready        = (state_q == DATA);
        dbg_state          = state_q;
    end

endmodule

// File: tb/tb_ibus_responder.sv
// Directed testbench for ibus_responder with a small burst-capable memory model.
// Line-buffer scenarios are compiled in when IBUS_LINEBUF_EN is defined.
module tb_ibus_responder;
    import ibus_pkg::*;

    logic        clk;
    logic        resetn;
    logic        linebuf_inv;
    logic        mem_ar_valid;
    logic        mem_ar_ready;
    logic [31:0] mem_ar_addr;
    logic [3:0]  mem_ar_len;
    logic        mem_r_valid;
    logic        mem_r_ready;
    logic [31:0] mem_r_data;
    logic        mem_r_last;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // memory model controls and observations
    int          ar_stall    = 0;
    int          r_stall_cfg = 0;
    int          ar_count    = 0;
    logic [31:0] last_ar_addr = '0;
    logic [3:0]  last_ar_len  = '0;

    ibus_responder_if ifc ();

    ibus_responder dut (
        .clk          (clk),
        .resetn       (resetn),
        .ibus         (ifc),
        .linebuf_inv  (linebuf_inv),
        .mem_ar_valid (mem_ar_valid),
        .mem_ar_ready (mem_ar_ready),
        .mem_ar_addr  (mem_ar_addr),
        .mem_ar_len   (mem_ar_len),
        .mem_r_valid  (mem_r_valid),
        .mem_r_ready  (mem_r_ready),
        .mem_r_data   (mem_r_data),
        .mem_r_last   (mem_r_last),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h1FC0_0000) return 32'h3C1D_0001;
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    initial begin : mem_model
        logic        ar_fire, r_fire, busy;
        logic [31:0] burst_addr;
        int          beats_left, r_wait;
        busy = 0; beats_left = 0; r_wait = 0; burst_addr = '0;
        mem_ar_ready = 1'b1; mem_r_valid = 1'b0; mem_r_data = '0; mem_r_last = 1'b0;
        forever begin
            @(negedge clk);
            ar_fire = mem_ar_valid && mem_ar_ready;
            r_fire  = mem_r_valid && mem_r_ready;
            if (ar_fire) begin
                last_ar_addr = mem_ar_addr;
                last_ar_len  = mem_ar_len;
                ar_count++;
            end
            @(posedge clk);
            #1;
            if (!resetn) begin
                busy = 0; mem_r_valid = 1'b0; mem_r_last = 1'b0; mem_r_data = '0;
                mem_ar_ready = 1'b1; ar_stall = 0;
            end else begin
                if (r_fire) begin
                    beats_left--;
                    burst_addr += 32'd4;
                    if (beats_left == 0) begin
                        busy = 0; mem_r_valid = 1'b0; mem_r_last = 1'b0;
                    end else begin
                        mem_r_data = word_at(burst_addr);
                        mem_r_last = (beats_left == 1);
                    end
                end
                if (ar_fire) begin
                    busy = 1; burst_addr = last_ar_addr;
                    beats_left = int'(last_ar_len) + 1;
                    r_wait = r_stall_cfg; mem_r_valid = 1'b0;
                end
                if (busy && !mem_r_valid) begin
                    if (r_wait > 0) r_wait--;
                    else begin
                        mem_r_valid = 1'b1;
                        mem_r_data  = word_at(burst_addr);
                        mem_r_last  = (beats_left == 1);
                    end
                end
                if (ar_stall > 0) begin
                    mem_ar_ready = 1'b0;
                    if (mem_ar_valid) ar_stall--;
                end else begin
                    mem_ar_ready = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one fetch; lat counts cycles from the accept cycle to the data_ok cycle (-1 on timeout).
    task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
        int waits;
        d = '0; lat = -1; waits = 0;
        @(negedge clk);
        ifc.ireq.valid = 1'b1; ifc.ireq.addr = a;
        #1;
        while (!ifc.iresp.addr_ok && waits < 20) begin
            @(negedge clk); #1; waits++;
        end
        if (!ifc.iresp.addr_ok) begin
            ifc.ireq.valid = 1'b0;
            return;
        end
        @(negedge clk);
        ifc.ireq.valid = 1'b0;
        for (int i = 1; i < 50; i++) begin
            if (ifc.iresp.data_ok) begin
                d = ifc.iresp.data; lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [71:0] obs;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        obs = {ifc.iresp.addr_ok, ifc.iresp.data_ok, ifc.iresp.data, mem_ar_valid,
               mem_ar_addr, mem_ar_len, mem_r_ready};
        n_checks++;
        if (obs !== 72'd0) $display("FAIL reset_outputs got %h exp 0", obs);
        else n_pass++;
        n_checks++;
        if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", dbg_state);
        else n_pass++;
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ifc.iresp.data_ok !== 1'b0) $display("FAIL reset_release_data_ok got %b exp 0", ifc.iresp.data_ok);
        else n_pass++;
    endtask

    task automatic test_single_read;
        logic [31:0] d;
        int          lat, base;
        base = ar_count;
        do_fetch(32'hBFC0_0000, d, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL single_latency got %0d exp 3", lat); else n_pass++;
        n_checks++;
        if (d !== 32'h3C1D_0001) $display("FAIL single_data got %h exp 3c1d0001", d); else n_pass++;
        n_checks++;
        if (last_ar_addr !== 32'h1FC0_0000) $display("FAIL single_ar_addr got %h exp 1fc00000", last_ar_addr);
        else n_pass++;
        n_checks++;
        if (last_ar_len !== 4'd0) $display("FAIL single_ar_len got %0d exp 0", last_ar_len); else n_pass++;
        n_checks++;
        if (ar_count - base !== 1) $display("FAIL single_ar_count got %0d exp 1", ar_count - base); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ifc.iresp.data_ok !== 1'b0) $display("FAIL single_pulse got %b exp 0", ifc.iresp.data_ok);
        else n_pass++;
        // misaligned request returns the aligned word
        do_fetch(32'hBFC0_0006, d, lat);
        n_checks++;
        if (last_ar_addr !== 32'h1FC0_0004) $display("FAIL misaligned_addr got %h exp 1fc00004", last_ar_addr);
        else n_pass++;
        n_checks++;
        if (d !== word_at(32'h1FC0_0004)) $display("FAIL misaligned_data got %h exp %h", d, word_at(32'h1FC0_0004));
        else n_pass++;
    endtask

    task automatic test_ar_stall;
        int lat;
        logic [31:0] d;
        @(negedge clk);
        ar_stall = 5;
        ifc.ireq.valid = 1'b1; ifc.ireq.addr = 32'hBFC0_0008;
        #1;
        n_checks++;
        if (ifc.iresp.addr_ok !== 1'b1) $display("FAIL stall_accept got %b exp 1", ifc.iresp.addr_ok);
        else n_pass++;
        @(negedge clk);
        ifc.ireq.valid = 1'b0;
        lat = -1; d = '0;
        for (int i = 1; i < 40; i++) begin
            if (ifc.iresp.data_ok) begin
                lat = i; d = ifc.iresp.data;
                break;
            end
            n_checks++;
            if (ifc.iresp.addr_ok !== 1'b0) $display("FAIL stall_addr_ok cycle %0d got %b exp 0", i, ifc.iresp.addr_ok);
            else n_pass++;
            if (i <= 6) begin
                n_checks++;
                if ({mem_ar_valid, mem_ar_addr} !== {1'b1, 32'h1FC0_0008})
                    $display("FAIL stall_ar_hold cycle %0d got %b/%h exp 1/1fc00008", i, mem_ar_valid, mem_ar_addr);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (lat !== 8) $display("FAIL stall_latency got %0d exp 8", lat); else n_pass++;
        n_checks++;
        if (d !== word_at(32'h1FC0_0008)) $display("FAIL stall_data got %h exp %h", d, word_at(32'h1FC0_0008));
        else n_pass++;
    endtask

    task automatic test_addr_change;
        logic [31:0] d;
        int lat;
        @(negedge clk);
        ifc.ireq.valid = 1'b1; ifc.ireq.addr = 32'hBFC0_0004;
        #1;
        n_checks++;
        if (ifc.iresp.addr_ok !== 1'b1) $display("FAIL chg_accept got %b exp 1", ifc.iresp.addr_ok);
        else n_pass++;
        @(negedge clk);
        ifc.ireq.addr = 32'hBFC0_0100;
        #1;
        n_checks++;
        if (ifc.iresp.addr_ok !== 1'b0) $display("FAIL chg_busy_addr_ok got %b exp 0", ifc.iresp.addr_ok);
        else n_pass++;
        lat = -1; d = '0;
        for (int i = 1; i < 30; i++) begin
            if (ifc.iresp.data_ok) begin lat = i; d = ifc.iresp.data; break; end
            @(negedge clk);
        end
        n_checks++;
        if (d !== word_at(32'h1FC0_0004)) $display("FAIL chg_first_data got %h exp %h", d, word_at(32'h1FC0_0004));
        else n_pass++;
        n_checks++;
        if (last_ar_addr !== 32'h1FC0_0004) $display("FAIL chg_first_addr got %h exp 1fc00004", last_ar_addr);
        else n_pass++;
        // valid still high: the new address is accepted as soon as the responder is idle
        @(negedge clk);
        #1;
        n_checks++;
        if (ifc.iresp.addr_ok !== 1'b1) $display("FAIL chg_second_accept got %b exp 1", ifc.iresp.addr_ok);
        else n_pass++;
        @(negedge clk);
        ifc.ireq.valid = 1'b0;
        lat = -1; d = '0;
        for (int i = 1; i < 30; i++) begin
            if (ifc.iresp.data_ok) begin lat = i; d = ifc.iresp.data; break; end
            @(negedge clk);
        end
        n_checks++;
        if (last_ar_addr !== 32'h1FC0_0100) $display("FAIL chg_second_addr got %h exp 1fc00100", last_ar_addr);
        else n_pass++;
        n_checks++;
        if (d !== word_at(32'h1FC0_0100)) $display("FAIL chg_second_data got %h exp %h", d, word_at(32'h1FC0_0100));
        else n_pass++;
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        logic [71:0] obs;
        int lat, waits;
        r_stall_cfg = 4;
        @(negedge clk);
        ifc.ireq.valid = 1'b1; ifc.ireq.addr = 32'hBFC0_0020;
        @(negedge clk);
        ifc.ireq.valid = 1'b0;
        waits = 0;
        while (!mem_r_ready && waits < 10) begin @(negedge clk); waits++; end
        n_checks++;
        if (mem_r_ready !== 1'b1) $display("FAIL areset_reach_data got %b exp 1", mem_r_ready);
        else n_pass++;
        #2;
        resetn = 1'b0;
        #1;
        obs = {ifc.iresp.addr_ok, ifc.iresp.data_ok, ifc.iresp.data, mem_ar_valid,
               mem_ar_addr, mem_ar_len, mem_r_ready};
        n_checks++;
        if (obs !== 72'd0) $display("FAIL areset_outputs got %h exp 0", obs); else n_pass++;
        n_checks++;
        if (dbg_state !== 2'd0) $display("FAIL areset_state got %0d exp 0", dbg_state); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        r_stall_cfg = 0;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({ifc.iresp.data_ok, dbg_state} !== 3'b000)
                $display("FAIL areset_quiet cycle %0d got %b/%0d exp 0/0", i, ifc.iresp.data_ok, dbg_state);
            else n_pass++;
        end
        do_fetch(32'hBFC0_0024, d, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL areset_after_latency got %0d exp 3", lat); else n_pass++;
        n_checks++;
        if (d !== word_at(32'h1FC0_0024)) $display("FAIL areset_after_data got %h exp %h", d, word_at(32'h1FC0_0024));
        else n_pass++;
    endtask

`ifdef IBUS_LINEBUF_EN
    task automatic test_linebuf;
        logic [31:0] d, a;
        int lat, base;
        base = ar_count;
        do_fetch(32'h9FC0_0010, d, lat);
        n_checks++;
        if (lat !== 6) $display("FAIL lb_miss_latency got %0d exp 6", lat); else n_pass++;
        n_checks++;
        if (d !== word_at(32'h1FC0_0010)) $display("FAIL lb_miss_data got %h exp %h", d, word_at(32'h1FC0_0010));
        else n_pass++;
        n_checks++;
        if ({last_ar_addr, last_ar_len} !== {32'h1FC0_0010, 4'd3})
            $display("FAIL lb_burst_ar got %h/%0d exp 1fc00010/3", last_ar_addr, last_ar_len);
        else n_pass++;
        for (int k = 1; k < 4; k++) begin
            a = 32'h9FC0_0010 + 32'(4 * k);
            do_fetch(a, d, lat);
            n_checks++;
            if (lat !== 1) $display("FAIL lb_hit_latency word %0d got %0d exp 1", k, lat); else n_pass++;
            n_checks++;
            if (d !== word_at(a & 32'h1FFF_FFFF))
                $display("FAIL lb_hit_data word %0d got %h exp %h", k, d, word_at(a & 32'h1FFF_FFFF));
            else n_pass++;
        end
        n_checks++;
        if (ar_count - base !== 1) $display("FAIL lb_hit_no_ar got %0d exp 1", ar_count - base); else n_pass++;

        // invalidate in the same cycle as a hit: hit served, next access misses
        fork
            do_fetch(32'h9FC0_0018, d, lat);
            begin @(negedge clk); linebuf_inv = 1'b1; @(negedge clk); linebuf_inv = 1'b0; end
        join
        n_checks++;
        if ({lat, d} !== {32'd1, word_at(32'h1FC0_0018)})
            $display("FAIL lb_inv_hit got %0d/%h exp 1/%h", lat, d, word_at(32'h1FC0_0018));
        else n_pass++;
        do_fetch(32'h9FC0_001C, d, lat);
        n_checks++;
        if ({lat, d} !== {32'd6, word_at(32'h1FC0_001C)})
            $display("FAIL lb_after_inv_miss got %0d/%h exp 6/%h", lat, d, word_at(32'h1FC0_001C));
        else n_pass++;

        // invalidate during a fill: requested word still returned, line left invalid
        @(negedge clk); linebuf_inv = 1'b1; @(negedge clk); linebuf_inv = 1'b0;
        fork
            do_fetch(32'h9FC0_0010, d, lat);
            begin repeat (3) @(negedge clk); linebuf_inv = 1'b1; @(negedge clk); linebuf_inv = 1'b0; end
        join
        n_checks++;
        if ({lat, d} !== {32'd6, word_at(32'h1FC0_0010)})
            $display("FAIL lb_inv_fill_data got %0d/%h exp 6/%h", lat, d, word_at(32'h1FC0_0010));
        else n_pass++;
        base = ar_count;
        do_fetch(32'h9FC0_0014, d, lat);
        n_checks++;
        if (ar_count - base !== 1) $display("FAIL lb_inv_fill_remiss got %0d exp 1", ar_count - base); else n_pass++;
        n_checks++;
        if ({last_ar_len, d} !== {4'd3, word_at(32'h1FC0_0014)})
            $display("FAIL lb_remiss_burst got %0d/%h exp 3/%h", last_ar_len, d, word_at(32'h1FC0_0014));
        else n_pass++;
        do_fetch(32'h9FC0_0018, d, lat);
        n_checks++;
        if (lat !== 1) $display("FAIL lb_refill_hit got %0d exp 1", lat); else n_pass++;

        // uncached alias of a buffered line still goes to memory as a single beat
        base = ar_count;
        do_fetch(32'hBFC0_0014, d, lat);
        n_checks++;
        if ({ar_count - base, last_ar_addr, last_ar_len} !== {32'd1, 32'h1FC0_0014, 4'd0})
            $display("FAIL lb_uncached_ar got %0d/%h/%0d exp 1/1fc00014/0", ar_count - base, last_ar_addr, last_ar_len);
        else n_pass++;
        n_checks++;
        if ({lat, d} !== {32'd3, word_at(32'h1FC0_0014)})
            $display("FAIL lb_uncached_data got %0d/%h exp 3/%h", lat, d, word_at(32'h1FC0_0014));
        else n_pass++;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        resetn = 1'b0;
        linebuf_inv = 1'b0;
        ifc.ireq.valid = 1'b0;
        ifc.ireq.addr = '0;
        test_reset();
        test_single_read();
        test_ar_stall();
        test_addr_change();
        test_async_reset();
`ifdef IBUS_LINEBUF_EN
        test_linebuf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ibus_responder.md
Name: ibus_responder

Overview:
- Responder end of the instruction bus: accepts ibus_req_t from the fetch stage and returns ibus_resp_t.
- Converts each accepted request into a read on a simple address/read-data memory channel toward the bus bridge.
- Returns exactly one data_ok pulse per accepted request.
- Optionally keeps a one-line buffer so sequential cached fetches hit without a memory read.

Parameters:
- PADDR_MASK, 32'h1FFF_FFFF, AND mask applied to the virtual address to form the physical address (kseg0/kseg1 fold).
- LINE_WORDS, 4, words per buffered line; used only with the optional feature; must be a power of 2.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous assert, active-low
- ireq  in  ibus_req_t  .valid (1), .addr (32)
- iresp  out  ibus_resp_t  .addr_ok (1), .data_ok (1), .data (32)
- linebuf_inv  in  1  invalidate line buffer; ignored without the macro
- mem_ar_valid  out  1  read-address valid
- mem_ar_ready  in  1  read-address accepted
- mem_ar_addr  out  32  physical byte address, word aligned
- mem_ar_len  out  4  beats minus 1
- mem_r_valid  in  1  read-data valid
- mem_r_ready  out  1  read-data ready
- mem_r_data  in  32  read data
- mem_r_last  in  1  final beat

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; all outputs 0, including iresp.data and mem_ar_addr.
  - Latched address cleared; line buffer invalid.
  - Any in-flight memory transaction is abandoned; the memory side is reset alongside.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - iresp.addr_ok = ireq.valid (combinational).
  - On valid: latch addr = ireq.addr & PADDR_MASK with [1:0] forced to 0; go to ADDR.
- ADDR:
  - mem_ar_valid=1, mem_ar_addr=latched address, mem_ar_len=0.
  - Hold all three stable until mem_ar_ready; then go to DATA.
- DATA:
  - mem_r_ready=1.
  - On mem_r_valid: capture mem_r_data into the response register; go to RESP.
  - mem_r_last is not checked for single-beat reads.
- RESP:
  - iresp.data_ok=1 for exactly one cycle, with iresp.data = captured word; next state IDLE.
  - iresp.data holds its value until the next capture.
- Latency (zero-wait memory): accept at cycle 0, AR at cycle 1, R at cycle 2, data_ok at cycle 3. Minimum 4 cycles between successive accepts.
- Address changes: changes on ireq.addr after acceptance are ignored until data_ok.
  - A fetch flush mid-transaction still receives the original transaction's data_ok; the fetch discards it.
- ireq.valid deasserting after acceptance does not cancel the transaction.
- At most one outstanding request; addr_ok=0 in every state except IDLE.
- Misaligned request address: bits [1:0] are dropped; the aligned word is returned.

Optional Feature:
- Macro: IBUS_LINEBUF_EN.
- Defined:
  - Adds one LINE_WORDS-word buffer with a line tag and valid bit.
  - Cached address (virtual addr[31:29] != 3'b101), valid buffer, tag match: IDLE accepts and goes directly to RESP with the buffered word. data_ok arrives 1 cycle after accept.
  - Cached miss: ADDR issues mem_ar_addr = line base and mem_ar_len = LINE_WORDS-1.
  - DATA fills beats in order; it leaves only on mem_r_valid && mem_r_last, then sets the buffer valid and returns the requested word in RESP.
  - Uncached addresses (kseg1) always take a single-beat read and never touch the buffer.
  - linebuf_inv clears valid next cycle.
  - linebuf_inv asserted during a fill: the fill completes and the requested word is still returned, but the buffer is left invalid.
  - linebuf_inv in the same cycle as a hit: the hit is served, and valid clears afterwards.
- Undefined:
  - No buffer; every request is a single-beat read with mem_ar_len=0.
  - linebuf_inv is unused.

Test Plan:
- Reset, then ireq.valid=1 at addr 32'hBFC00000 with a zero-wait memory returning 32'h3C1D0001 -> mem_ar_addr=32'h1FC00000, len=0; data_ok=1 with data=32'h3C1D0001 exactly 3 cycles after accept; single-cycle pulse.
- mem_ar_ready held low for 5 cycles -> mem_ar_valid/addr stay stable; data_ok is delayed by 5 cycles; addr_ok stays 0 throughout.
- ireq.addr changes from 32'hBFC00004 to 32'hBFC00100 one cycle after accept -> the returned word is from 32'h1FC00004; next accept uses 32'h1FC00100.
- Async resetn=0 asserted mid-DATA -> outputs 0 immediately; after release, a new request completes normally with no spurious data_ok.
- IBUS_LINEBUF_EN, cached addr 32'h9FC00010 miss -> one 4-beat burst at 32'h1FC00010 returning words W0..W3 -> data=W0. Following requests at 0x9FC00014/18/1C -> no AR, data_ok 1 cycle after each accept with W1/W2/W3.
- IBUS_LINEBUF_EN:
  - linebuf_inv pulsed during that fill -> the fill still returns W0.
  - The next request at 0x9FC00014 misses and issues a new burst.
  - Uncached 32'hBFC00014 -> single-beat read even after a valid fill.
